// File: rtl/apb2axi_rdf_mt_pkg.sv
// Shared definitions for the multi-tag read data buffer.
//   rdf_mt_entry_t : one stored R beat {data, resp, last} at default widths
//   RDF_*          : default sizing used by apb2axi_rdf_mt and its tag queues
package apb2axi_rdf_mt_pkg;

  localparam int RDF_NUM_TAGS = 4;
  localparam int RDF_DEPTH    = 8;
  localparam int RDF_CNT_W    = $clog2(RDF_DEPTH + 1);
  localparam int RDF_DATA_W   = 64;
  localparam int RDF_RESP_W   = 2;

  typedef struct packed {
    logic [RDF_DATA_W-1:0] data;
    logic [RDF_RESP_W-1:0] resp;
    logic                  last;
  } rdf_mt_entry_t;

endpackage

// File: rtl/apb2axi_tag_queue.sv
// One per-tag circular buffer with occupancy level and complete-burst counter.
// Ports:
//   ACLK, ARESET  clock, asynchronous active-high reset
//   push          write push_entry at the tail (caller guarantees not full)
//   push_entry    beat to store
//   pop           drop the head entry (caller guarantees not empty)
//   clear         discard everything; overrides push and pop
//   head          entry at the read pointer
//   level         number of stored beats, 0..DEPTH
//   burst_cnt     number of stored beats flagged last
module apb2axi_tag_queue
  import apb2axi_rdf_mt_pkg::*;
#(
  parameter int  DEPTH   = RDF_DEPTH,
  parameter int  CNT_W   = $clog2(DEPTH + 1),
  parameter type entry_t = rdf_mt_entry_t
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             clear,
  output entry_t           head,
  output logic [CNT_W-1:0] level,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             burst_inc;
  logic             burst_dec;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head      = mem[rd_ptr];
  assign burst_inc = push && push_entry.last;
  assign burst_dec = pop && head.last;

  always_ff @(posedge ACLK) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      burst_cnt <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      burst_cnt <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      case ({burst_inc, burst_dec})
        2'b10:   burst_cnt <= burst_cnt + 1'b1;
        2'b01:   burst_cnt <= burst_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/apb2axi_rdf_mt.sv
// Multi-tag read data buffer: one independent FIFO per AXI tag so interleaved
// R beats are returned to the APB side in per-tag order.
// Ports:
//   ACLK, ARESET                  clock, asynchronous active-high reset
//   push_*                        beat from the response collector (valid/ready)
//   data_req, data_req_tag        pop request, answered one cycle later
//   data_valid/out/resp/last      popped beat (registered, held when idle)
//   data_miss                     request hit an empty, invalid or flushed tag
//   flush, flush_tag              discard all contents of one tag
//   tag_level                     per-tag occupancy, tag 0 in the LSBs
//   tag_burst_done                per-tag "holds a complete burst"
module apb2axi_rdf_mt
  import apb2axi_rdf_mt_pkg::*;
#(
  parameter int NUM_TAGS = RDF_NUM_TAGS,
  parameter int TAG_W    = 2,
  parameter int DATA_W   = RDF_DATA_W,
  parameter int RESP_W   = RDF_RESP_W,
  parameter int DEPTH    = RDF_DEPTH,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      push_valid,
  input  logic [TAG_W-1:0]          push_tag,
  input  logic [DATA_W-1:0]         push_data,
  input  logic [RESP_W-1:0]         push_resp,
  input  logic                      push_last,
  output logic                      push_ready,
  input  logic                      data_req,
  input  logic [TAG_W-1:0]          data_req_tag,
  output logic                      data_valid,
  output logic [DATA_W-1:0]         data_out,
  output logic [RESP_W-1:0]         data_resp,
  output logic                      data_last,
  output logic                      data_miss,
  input  logic                      flush,
  input  logic [TAG_W-1:0]          flush_tag,
  output logic [NUM_TAGS*CNT_W-1:0] tag_level,
  output logic [NUM_TAGS-1:0]       tag_burst_done
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  entry_t              push_entry;
  entry_t              head [NUM_TAGS];
  entry_t              head_sel;
  logic [CNT_W-1:0]    level [NUM_TAGS];
  logic [CNT_W-1:0]    burst_cnt [NUM_TAGS];
  logic [NUM_TAGS-1:0] push_sel;
  logic [NUM_TAGS-1:0] pop_sel;
  logic [NUM_TAGS-1:0] clr_sel;
  logic                pop_hit;

  assign push_entry.data = push_data;
  assign push_entry.resp = push_resp;
  assign push_entry.last = push_last;

  // Tags >= NUM_TAGS never match any loop index, so they are never ready,
  // always miss and cannot flush anything. Both decisions use registered
  // levels only, so a same-cycle pop never frees space for a push.
  always_comb begin
    push_ready = 1'b0;
    pop_hit    = 1'b0;
    head_sel   = '0;
    push_sel   = '0;
    pop_sel    = '0;
    clr_sel    = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      clr_sel[i] = flush && (flush_tag == TAG_W'(i));
      if ((push_tag == TAG_W'(i)) && (level[i] != FULL_LVL) && !clr_sel[i]) begin
        push_ready  = 1'b1;
        push_sel[i] = push_valid;
      end
      if (data_req && (data_req_tag == TAG_W'(i)) && (level[i] != '0) && !clr_sel[i]) begin
        pop_hit    = 1'b1;
        pop_sel[i] = 1'b1;
        head_sel   = head[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    apb2axi_tag_queue #(
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (entry_t)
    ) u_queue (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .push       (push_sel[g]),
      .push_entry (push_entry),
      .pop        (pop_sel[g]),
      .clear      (clr_sel[g]),
      .head       (head[g]),
      .level      (level[g]),
      .burst_cnt  (burst_cnt[g])
    );
    assign tag_level[g*CNT_W +: CNT_W] = level[g];
    assign tag_burst_done[g]           = (burst_cnt[g] != '0);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      data_valid <= 1'b0;
      data_miss  <= 1'b0;
      data_out   <= '0;
      data_resp  <= '0;
      data_last  <= 1'b0;
    end else begin
      data_valid <= pop_hit;
      data_miss  <= data_req && !pop_hit;
      if (pop_hit) begin
        data_out  <= head_sel.data;
        data_resp <= head_sel.resp;
        data_last <= head_sel.last;
      end
    end
  end

endmodule

// File: doc/apb2axi_rdf_mt.md
Name: apb2axi_rdf_mt

Overview:
Multi-tag read data buffer. It stores AXI R beats in one independent queue per TAG, so responses from different IDs may arrive interleaved. The APB-side consumer requests "next beat for TAG N" and receives beats for that tag in order, regardless of traffic on other tags. It sits between the response collector (push side) and the APB read-data path. It is single-clock and adds per-tag occupancy, burst-complete status and per-tag flush.

Parameters:
NUM_TAGS, 4, number of tags (independent queues); must be ≥2.
TAG_W, 2, tag field width; must be ≥ $clog2(NUM_TAGS).
DATA_W, 64, R data width.
RESP_W, 2, R response width.
DEPTH, 8, beats per tag queue; must be ≥2, not necessarily a power of two.
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
push_valid  in  1  beat offered by the response collector
push_tag  in  TAG_W  tag of the offered beat
push_data  in  DATA_W  beat data
push_resp  in  RESP_W  beat RRESP
push_last  in  1  beat is RLAST
push_ready  out  1  beat accepted this cycle when push_valid is also high
data_req  in  1  request the next beat for data_req_tag (sampled each cycle)
data_req_tag  in  TAG_W  requested tag
data_valid  out  1  one-cycle pulse: data_out/data_resp/data_last valid
data_out  out  DATA_W  popped data
data_resp  out  RESP_W  popped RRESP
data_last  out  1  popped beat was last of its burst
data_miss  out  1  one-cycle pulse: request hit an empty, invalid or flushed tag
flush  in  1  discard all contents of flush_tag
flush_tag  in  TAG_W  tag to flush
tag_level  out  NUM_TAGS*CNT_W  per-tag occupancy, packed with tag 0 in the LSBs
tag_burst_done  out  NUM_TAGS  bit i is high when tag i holds at least one complete burst

Behaviour:
- Reset (ARESET high, asynchronous):
  - All queues empty; all pointers, levels and burst counters are 0.
  - data_valid, data_miss, data_out, data_resp and data_last are all 0.
  - Outputs hold those values until ARESET deasserts.
- Storage:
  - One circular buffer of DEPTH entries per tag, holding {data, resp, last}.
  - Read/write pointers wrap explicitly from DEPTH-1 to 0.
  - Per-tag level counter runs 0..DEPTH.
- Push path:
  - push_ready is combinational: tag valid (push_tag < NUM_TAGS) AND level[push_tag] < DEPTH AND NOT (flush AND flush_tag==push_tag).
  - On push_valid && push_ready: write the entry, advance the write pointer, level +1.
  - If push_last is also set, burst_cnt[tag] +1.
  - push_ready must not depend on a same-cycle pop, so a full tag stays not-ready even while being popped.
- Pop path (1-cycle latency):
  - A request is sampled in cycle T.
  - If tag is valid, level>0 and the tag is not being flushed: in T+1, data_valid=1 with that tag's head entry, read pointer advances, level -1.
  - If the popped beat has last=1, burst_cnt[tag] -1.
  - Otherwise: data_miss=1 in T+1, and data_valid=0.
  - data_out, data_resp and data_last hold their last popped values when data_valid=0.
- Simultaneous events:
  - Push and pop on the same tag in one cycle: the pop sees pre-push state. An empty tag receiving a push yields a miss; the level is unchanged when both succeed.
  - Push and pop on different tags are fully independent.
  - Flush on tag X wins over a push or pop to X in the same cycle: the push is not accepted and the pop reports a miss. After the edge, X's pointers, level and burst_cnt are 0.
  - Flush of one tag never disturbs the other tags.
- Status outputs:
  - tag_level[i] is the registered level.
  - tag_burst_done[i] = (burst_cnt[i] != 0).
  - burst_cnt is CNT_W wide and never exceeds level.
- Requests with data_req_tag ≥ NUM_TAGS always miss and change no state.

Decomposition:
- Shared package: rdf_mt_entry_t {data, resp, last} struct and the default NUM_TAGS, DEPTH and CNT_W localparams.
- Sub-module apb2axi_tag_queue: one circular buffer with level and burst counter plus push/pop/clear strobes. It is instantiated NUM_TAGS times under a generate loop.
- The top level owns push/pop/flush decode, output registers and status packing.

Test Plan:
- Basic order: push 4 beats to tag 1 (data 0x10..0x13, last on 0x13), then data_req tag 1 for four cycles → data_valid pulses with 0x10..0x13, data_last only on 0x13; tag_burst_done[1] drops after the last pop.
- Interleave: alternate pushes tag0 A0,A1(last) and tag2 B0,B1(last); request tag2 twice, then tag0 twice → B0,B1 then A0,A1; tag_level is 0 everywhere at the end.
- Full/backpressure: push 8 beats to tag 3, then a 9th → push_ready=0, tag_level[3]=8; a same-cycle pop still leaves the 9th beat unaccepted; after the pop, the push is accepted.
- Empty/miss: data_req tag 0 when empty → data_miss=1 one cycle later, data_valid=0. Push to tag 0 in the same cycle as the request → still a miss, and tag_level[0]=1 afterwards.
- Flush: tag 1 holds 3 beats and tag 2 holds 2; flush tag 1 with a concurrent data_req tag 1 → data_miss=1, tag_level[1]=0, tag_burst_done[1]=0, tag 2 unchanged and still pops correctly.
- Async reset mid-traffic: assert ARESET between clock edges while tags hold data → outputs clear immediately without a clock edge; after release all levels are 0 and a request misses.
